bit_serial_add_ctrl: RTL and testbench

Sequencer that time-shares one 1-bit full adder (`FA`: A, B, C0 -> S, C1) to add or subtract two WIDTH-bit operands LSB-first, one bit per clock. It holds the operand and result shift registers and the carry flop, and presents a start/busy/done handshake to the upstream delta-sigma accumulator logic. The full adder stays a separate combinational instance wired to the `fa_*` ports, so the same verified cell is reused unchanged.

---
 rtl/bit_serial_add_ctrl.sv | 145 ++++++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_add_ctrl.sv
// bit_serial_add_ctrl
// Sequencer that time-shares one external 1-bit full adder to add or
// subtract two WIDTH-bit operands LSB-first, one bit per clock.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, sub        operation request; 0 = A+B, 1 = A-B (sampled with start)
//   op_a, op_b        operands, sampled with start in IDLE or DONE
//   busy              high while the bit-serial pass is running
//   done              one-cycle pulse, sum/cout/ovf valid
//   sum, cout, ovf    result, carry out of MSB, signed overflow
//   fa_a, fa_b, fa_c0 drive the external full adder (0 outside RUN)
//   fa_s, fa_c1       full adder sum and carry outputs
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per cycle through the full adder
// DONE  | result just completed; start here begins the next operation
module bit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c0,
  input  logic             fa_s,
  input  logic             fa_c1
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_r_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_r_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_run  = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        if (r_bit_cnt == LAST_CNT) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Result shifts in from the MSB so that after WIDTH bits it is aligned.
  assign w_r_next = {fa_s, r_r_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_r_sh    <= '0;
      r_carry   <= 1'b0;
      r_bit_cnt <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_load) begin
      // Subtract as A + ~B + 1: invert B and seed the carry with 1.
      r_a_sh    <= op_a;
      r_b_sh    <= op_b ^ {WIDTH{sub}};
      r_carry   <= sub;
      r_bit_cnt <= '0;
    end else if (w_run) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_r_sh  <= w_r_next;
      r_carry <= fa_c1;
      if (w_last) begin
        r_sum  <= w_r_next;
        r_cout <= fa_c1;
        // r_carry here is the carry into the MSB.
        r_ovf  <= r_carry ^ fa_c1;
      end else begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign sum   = r_sum;
  assign cout  = r_cout;
  assign ovf   = r_ovf;
  assign fa_a  = w_run & r_a_sh[0];
  assign fa_b  = w_run & r_b_sh[0];
  assign fa_c0 = w_run & r_carry;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Testbench for bit_serial_add_ctrl: a WIDTH=8 instance for directed
// vectors and a WIDTH=4 instance for an exhaustive sweep, each with its
// own combinational full adder attached to the fa_* ports.
module tb_bit_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       fa_a8, fa_b8, fa_c08, fa_s8, fa_c18;

  assign fa_s8  = fa_a8 ^ fa_b8 ^ fa_c08;
  assign fa_c18 = (fa_a8 & fa_b8) | (fa_a8 & fa_c08) | (fa_b8 & fa_c08);

  bit_serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .ovf(ovf8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_c0(fa_c08),
    .fa_s(fa_s8), .fa_c1(fa_c18)
  );

  // WIDTH=4 instance
  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;
  logic       fa_a4, fa_b4, fa_c04, fa_s4, fa_c14;

  assign fa_s4  = fa_a4 ^ fa_b4 ^ fa_c04;
  assign fa_c14 = (fa_a4 & fa_b4) | (fa_a4 & fa_c04) | (fa_b4 & fa_c04);

  bit_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4),
    .op_a(a4), .op_b(b4), .busy(busy4), .done(done4),
    .sum(sum4), .cout(cout4), .ovf(ovf4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_c0(fa_c04),
    .fa_s(fa_s4), .fa_c1(fa_c14)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus helper: issue one op on the 8-bit instance and wait for done.
  // lat = edges after the start edge until done is seen; bcnt = cycles busy.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output int lat, output int bcnt, output bit to,
                      output logic [2:0] fa_first);
    @(posedge clk); #1;
    start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; sub8 = ~s;
    fa_first = {fa_a8, fa_b8, fa_c08};
    bcnt = busy8 ? 1 : 0;
    lat = 0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
      if (done8) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy8, done8, sum8, cout8, ovf8, fa_a8, fa_b8, fa_c08} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b fa=%b%b%b, want all 0",
               busy8, done8, sum8, cout8, ovf8, fa_a8, fa_b8, fa_c08);
    end
    n_tests++;
    if ({busy4, done4, sum4, cout4, ovf4, fa_a4, fa_b4, fa_c04} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy4, done4, sum4, cout4, ovf4);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, bcnt;
    bit to;
    logic [2:0] faf;
    run8(8'h5A, 8'h3C, 1'b0, lat, bcnt, to, faf);
    n_tests++;
    if (to || lat != 8) begin
      n_fail++;
      $display("FAIL add_latency: got timeout=%0d edges=%0d, want edges=8", to, lat);
    end
    n_tests++;
    if (bcnt != 8) begin
      n_fail++;
      $display("FAIL add_busy_cycles: got %0d, want 8", bcnt);
    end
    n_tests++;
    if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_5A_3C: got sum=%h cout=%b ovf=%b, want 96 0 1", sum8, cout8, ovf8);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", done8, busy8);
    end
    n_tests++;
    if (sum8 !== 8'h96) begin
      n_fail++;
      $display("FAIL sum_hold_idle: got %h, want 96", sum8);
    end

    run8(8'hFF, 8'h01, 1'b0, lat, bcnt, to, faf);
    n_tests++;
    if (to || {sum8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_FF_01: got timeout=%0d sum=%h cout=%b ovf=%b, want 00 1 0",
               to, sum8, cout8, ovf8);
    end
    run8(8'h7F, 8'h01, 1'b0, lat, bcnt, to, faf);
    n_tests++;
    if (to || {sum8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_7F_01: got timeout=%0d sum=%h cout=%b ovf=%b, want 80 0 1",
               to, sum8, cout8, ovf8);
    end
  endtask

  task automatic test_sub();
    int lat, bcnt;
    bit to;
    logic [2:0] faf;
    run8(8'h10, 8'h20, 1'b1, lat, bcnt, to, faf);
    n_tests++;
    if (faf !== 3'b011) begin
      n_fail++;
      $display("FAIL sub_first_fa: got a,b,c0=%b, want 011", faf);
    end
    n_tests++;
    if (to || {sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_10_20: got timeout=%0d sum=%h cout=%b ovf=%b, want F0 0 0",
               to, sum8, cout8, ovf8);
    end
    run8(8'h80, 8'h01, 1'b1, lat, bcnt, to, faf);
    n_tests++;
    if (to || {sum8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_80_01: got timeout=%0d sum=%h cout=%b ovf=%b, want 7F 1 1",
               to, sum8, cout8, ovf8);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    bit to;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    repeat (3) begin
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
    @(posedge clk); #1;
    lat++;
    start8 = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (to || lat != 8) begin
      n_fail++;
      $display("FAIL ignore_latency: got timeout=%0d edges=%0d, want edges=8", to, lat);
    end
    n_tests++;
    if ({sum8, cout8, ovf8} !== {8'h46, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b, want 46 0 0", sum8, cout8, ovf8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [3];
    logic [7:0] tb_ [3];
    logic       ts [3];
    logic [9:0] exp [3];
    int edge_n, last_done;
    bit to;
    ta[0] = 8'h01; tb_[0] = 8'h02; ts[0] = 1'b0; exp[0] = {8'h03, 1'b0, 1'b0};
    ta[1] = 8'h90; tb_[1] = 8'h90; ts[1] = 1'b0; exp[1] = {8'h20, 1'b1, 1'b1};
    ta[2] = 8'h05; tb_[2] = 8'h07; ts[2] = 1'b1; exp[2] = {8'hFE, 1'b0, 1'b0};
    @(posedge clk); #1;
    start8 = 1'b1; a8 = ta[0]; b8 = tb_[0]; sub8 = ts[0];
    @(posedge clk); #1;
    edge_n = 0;
    last_done = 0;
    for (int k = 0; k < 3; k++) begin
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        edge_n++;
        if (done8) begin
          to = 1'b0;
          break;
        end
      end
      n_tests++;
      if (to || (edge_n - last_done) != ((k == 0) ? 8 : 9)) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got timeout=%0d spacing=%0d, want %0d",
                 k, to, edge_n - last_done, (k == 0) ? 8 : 9);
      end
      n_tests++;
      if ({sum8, cout8, ovf8} !== exp[k]) begin
        n_fail++;
        $display("FAIL b2b_result%0d: got sum=%h cout=%b ovf=%b, want %h %b %b",
                 k, sum8, cout8, ovf8, exp[k][9:2], exp[k][1], exp[k][0]);
      end
      last_done = edge_n;
      if (k < 2) begin
        a8 = ta[k+1]; b8 = tb_[k+1]; sub8 = ts[k+1];
      end else begin
        start8 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midop();
    int lat, bcnt;
    bit to;
    bit saw_done;
    logic [2:0] faf;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy8, done8, sum8, cout8, ovf8, fa_a8, fa_b8, fa_c08} !== 15'd0) begin
      n_fail++;
      $display("FAIL midop_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b fa=%b%b%b, want all 0",
               busy8, done8, sum8, cout8, ovf8, fa_a8, fa_b8, fa_c08);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done8) saw_done = 1'b1;
    end
    #2 rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL midop_no_done: got done/busy activity after abort, want none");
    end
    run8(8'h01, 8'h01, 1'b0, lat, bcnt, to, faf);
    n_tests++;
    if (to || {sum8, cout8, ovf8} !== {8'h02, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midop_fresh: got timeout=%0d sum=%h cout=%b ovf=%b, want 02 0 0",
               to, sum8, cout8, ovf8);
    end
  endtask

  task automatic test_sweep4();
    logic [4:0] full;
    logic [3:0] es;
    logic       eo;
    bit to, fa_bad;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          if (s == 1) full = 5'(a) + 5'((~b) & 15) + 5'd1;
          else        full = 5'(a) + 5'(b);
          es = full[3:0];
          if (s == 1) eo = (a[3] != b[3]) && (es[3] != a[3]);
          else        eo = (a[3] == b[3]) && (es[3] != a[3]);
          fa_bad = 1'b0;
          @(posedge clk); #1;
          if (!busy4 && (fa_a4 | fa_b4 | fa_c04)) fa_bad = 1'b1;
          start4 = 1'b1; a4 = 4'(a); b4 = 4'(b); sub4 = s[0];
          @(posedge clk); #1;
          start4 = 1'b0;
          to = 1'b1;
          for (int i = 0; i < 12; i++) begin
            if (!busy4 && (fa_a4 | fa_b4 | fa_c04)) fa_bad = 1'b1;
            if (done4) begin
              to = 1'b0;
              break;
            end
            @(posedge clk); #1;
          end
          n_tests++;
          if (to || {sum4, cout4, ovf4} !== {es, full[4], eo}) begin
            n_fail++;
            $display("FAIL sweep4 a=%h b=%h sub=%0d: got timeout=%0d sum=%h cout=%b ovf=%b, want %h %b %b",
                     a, b, s, to, sum4, cout4, ovf4, es, full[4], eo);
          end
          n_tests++;
          if (fa_bad) begin
            n_fail++;
            $display("FAIL sweep4_fa_idle a=%h b=%h sub=%0d: got nonzero fa_* with busy=0, want 0", a, b, s);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    test_sweep4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
